keccak_nonce_checker: RTL

- Sits directly downstream of the unrolled Keccak-f[1600] pipeline. Consumes its 1600-bit OutState every cycle.
- Re-associates each result with the nonce issued alongside it, using a valid/nonce delay line matched to the core latency. The core itself carries no sideband.
- Compares one 64-bit state lane against a share target. Queues winning nonces in a small FIFO with a valid/ready interface towards the host/UART side.

---
 rtl/keccak_nonce_checker.sv | 133 +++++++++++++
 1 files changed

// File: rtl/keccak_nonce_checker.sv
`timescale 1ns/1ps
// keccak_nonce_checker: re-associates Keccak-f[1600] pipeline results with the
// nonces issued alongside them, compares one 64-bit lane against a share target
// and queues winning nonces in a small result FIFO for the host.
//
// Ports:
//   clk, rst           single clock, asynchronous active-high reset
//   in_valid, in_nonce tag entering the core's InState this cycle
//   keccak_out         core OutState (unregistered)
//   target             share target, sampled at the compare point
//   out_valid/ready    result FIFO head handshake
//   out_nonce/out_lane winning nonce and its compared lane at the FIFO head
//   fifo_full          FIFO holds FIFO_DEPTH entries
//   hit_count          saturating count of all hits
//   drop_count         saturating count of hits lost to a full FIFO
module keccak_nonce_checker #(
    parameter int unsigned LATENCY    = 47,
    parameter int unsigned CHECK_LANE = 6,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned NONCE_W    = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [NONCE_W-1:0] in_nonce,
    input  logic [1599:0]      keccak_out,
    input  logic [63:0]        target,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NONCE_W-1:0] out_nonce,
    output logic [63:0]        out_lane,
    output logic               fifo_full,
    output logic [31:0]        hit_count,
    output logic [15:0]        drop_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef struct packed {
        logic [NONCE_W-1:0] nonce;
        logic [63:0]        lane;
    } entry_t;

    // Only one lane is inspected; fold the whole state so it counts as consumed.
    logic unused_state_bits;
    assign unused_state_bits = ^keccak_out;

    // Delay line: valid bits are reset, nonce bits are don't-care.
    logic [LATENCY-1:0] dl_valid;
    logic [NONCE_W-1:0] dl_nonce [LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl_valid <= '0;
        end else begin
            dl_valid[0] <= in_valid;
            for (int i = 1; i < int'(LATENCY); i++) dl_valid[i] <= dl_valid[i-1];
        end
    end

    always_ff @(posedge clk) begin
        dl_nonce[0] <= in_nonce;
        for (int i = 1; i < int'(LATENCY); i++) dl_nonce[i] <= dl_nonce[i-1];
    end

    logic        aligned_valid;
    logic [63:0] lane;
    assign aligned_valid = dl_valid[LATENCY-1];
    assign lane          = keccak_out[CHECK_LANE*64 +: 64];

    // Compare stage: the target is taken live, no per-nonce capture.
    logic   hit_r;
    entry_t cmp_entry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_r     <= 1'b0;
            cmp_entry <= '0;
        end else begin
            hit_r           <= aligned_valid && (lane <= target);
            cmp_entry.nonce <= dl_nonce[LATENCY-1];
            cmp_entry.lane  <= lane;
        end
    end

    // Result FIFO with one extra pointer bit to tell full from empty.
    entry_t        mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] occupancy;
    logic          pop;
    logic          push;
    logic          drop;
    entry_t        head;

    assign occupancy = wr_ptr - rd_ptr;
    assign fifo_full = (occupancy == PW'(FIFO_DEPTH));
    assign out_valid = (wr_ptr != rd_ptr);
    assign pop       = out_valid && out_ready;
    // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
    assign push      = hit_r && (!fifo_full || pop);
    assign drop      = hit_r && fifo_full && !pop;
    assign head      = mem[rd_ptr[AW-1:0]];
    assign out_nonce = out_valid ? head.nonce : '0;
    assign out_lane  = out_valid ? head.lane  : '0;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= cmp_entry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Saturating event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            drop_count <= '0;
        end else begin
            if (hit_r && hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
            if (drop && drop_count != 16'hFFFF)      drop_count <= drop_count + 16'd1;
        end
    end

endmodule
